// File: rtl/msp_enc_pkg.sv
// Shared types and constants for the MSP430 instruction encoder.
// Optional feature macro: MSP_ENC_SWBRK_EN (software-breakpoint encoding).
`ifndef DBG_SWBRK_OP
`define DBG_SWBRK_OP 16'h4343
`endif

package msp_enc_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned JOFF_W = 10;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        CMD_SIGOP  = 2'b00,
        CMD_JUMP   = 2'b01,
        CMD_TWOOP  = 2'b10,
        CMD_SBREAK = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OPW  = 2'b01,
        ST_EXT1 = 2'b10,
        ST_EXT2 = 2'b11
    } enc_state_e;

    localparam logic [WORD_W-1:0] RETI_WORD     = 16'h1300;
    localparam logic [OP_W-1:0]   TWOOP_MIN_OP  = 4'd4;
    localparam logic [2:0]        SIGOP_RETI    = 3'd6;
    localparam logic [2:0]        SIGOP_ILLEGAL = 3'd7;

    // Command fields needed to build the opcode word
    typedef struct packed {
        cmd_type_e          ctype;
        logic [OP_W-1:0]    op;
        logic               bw;
        logic [REG_W-1:0]   src;
        logic [1:0]         src_as;
        logic [REG_W-1:0]   dst;
        logic               dst_ad;
        logic [JOFF_W-1:0]  jmp_off;
    } enc_cmd_t;

endpackage

// File: rtl/msp_inst_encoder_if.sv
// Command and word-stream bus of the instruction encoder.
// Optional feature macro: MSP_ENC_SWBRK_EN (no effect on this interface).
interface msp_inst_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_op;
    logic        cmd_bw;
    logic [3:0]  cmd_src;
    logic [1:0]  cmd_as;
    logic [3:0]  cmd_dst;
    logic        cmd_ad;
    logic [15:0] cmd_src_ext;
    logic [15:0] cmd_dst_ext;
    logic        base_load;
    logic [15:0] base_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_last;
    logic        cmd_err;
    logic [31:0] inst_count;

    modport slave (
        input  cmd_valid, cmd_type, cmd_op, cmd_bw, cmd_src, cmd_as, cmd_dst,
               cmd_ad, cmd_src_ext, cmd_dst_ext, base_load, base_addr, wr_ready,
        output cmd_ready, wr_valid, wr_addr, wr_data, wr_last, cmd_err, inst_count
    );

    modport master (
        output cmd_valid, cmd_type, cmd_op, cmd_bw, cmd_src, cmd_as, cmd_dst,
               cmd_ad, cmd_src_ext, cmd_dst_ext, base_load, base_addr, wr_ready,
        input  cmd_ready, wr_valid, wr_addr, wr_data, wr_last, cmd_err, inst_count
    );
endinterface

// File: rtl/msp_inst_assemble.sv
// Combinational opcode-word builder plus extension-word and legality flags.
// Optional feature macro: MSP_ENC_SWBRK_EN (SBREAK legal and encoded when defined).
module msp_inst_assemble
    import msp_enc_pkg::*;
(
    input  enc_cmd_t            i_cmd,
    output logic [WORD_W-1:0]   o_word_c,
    output logic                o_need_src_c,
    output logic                o_need_dst_c,
    output logic                o_illegal_c
);

    logic w_src_ext;

    // Indexed/symbolic/absolute source (As=01, not CG2) or immediate (As=11 on PC)
    assign w_src_ext = ((i_cmd.src_as == 2'b01) && (i_cmd.src != 4'd3)) ||
                       ((i_cmd.src_as == 2'b11) && (i_cmd.src == 4'd0));

    // Opcode word per command type
    always_comb begin
        o_word_c     = '0;
        o_need_src_c = 1'b0;
        o_need_dst_c = 1'b0;
        o_illegal_c  = 1'b0;
        case (i_cmd.ctype)
            CMD_TWOOP: begin
                o_word_c     = {i_cmd.op, i_cmd.src, i_cmd.dst_ad, i_cmd.bw,
                                i_cmd.src_as, i_cmd.dst};
                o_need_src_c = w_src_ext;
                o_need_dst_c = i_cmd.dst_ad;
                o_illegal_c  = (i_cmd.op < TWOOP_MIN_OP);
            end
            CMD_SIGOP: begin
                if (i_cmd.op[2:0] == SIGOP_RETI) begin
                    o_word_c = RETI_WORD;
                end else begin
                    o_word_c     = {6'b000100, i_cmd.op[2:0], i_cmd.bw,
                                    i_cmd.src_as, i_cmd.src};
                    o_need_src_c = w_src_ext;
                end
                o_illegal_c = (i_cmd.op[2:0] == SIGOP_ILLEGAL);
            end
            CMD_JUMP: begin
                o_word_c = {3'b001, i_cmd.op[2:0], i_cmd.jmp_off};
            end
            CMD_SBREAK: begin
`ifdef MSP_ENC_SWBRK_EN
                o_word_c = `DBG_SWBRK_OP;
`else
                o_illegal_c = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/msp_inst_encoder.sv
// MSP430 instruction encoder: accepts one command, streams its opcode and
// extension words with byte addresses, counts completed instructions.
// Optional feature macro: MSP_ENC_SWBRK_EN (SBREAK emits `DBG_SWBRK_OP).
module msp_inst_encoder
    import msp_enc_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR = 16'hF000
) (
    input  logic                mclk,
    input  logic                puc,
    msp_inst_encoder_if.slave   bus
);

    enc_cmd_t           w_cmd;
    logic [WORD_W-1:0]  w_word;
    logic               w_need_src;
    logic               w_need_dst;
    logic               w_illegal;
    logic               w_cmd_ready;
    logic               w_accept;
    logic               w_wr_hs;

    enc_state_e         r_state;
    logic               r_wr_valid;
    logic               r_wr_last;
    logic [WORD_W-1:0]  r_wr_data;
    logic [WORD_W-1:0]  r_wr_addr;
    logic [CNT_W-1:0]   r_inst_count;
    logic               r_cmd_err;
    logic               r_need_src;
    logic               r_need_dst;
    logic [WORD_W-1:0]  r_src_ext;
    logic [WORD_W-1:0]  r_dst_ext;

    // Pack the command bus for the assembler
    always_comb begin
        w_cmd.ctype   = cmd_type_e'(bus.cmd_type);
        w_cmd.op      = bus.cmd_op;
        w_cmd.bw      = bus.cmd_bw;
        w_cmd.src     = bus.cmd_src;
        w_cmd.src_as  = bus.cmd_as;
        w_cmd.dst     = bus.cmd_dst;
        w_cmd.dst_ad  = bus.cmd_ad;
        w_cmd.jmp_off = bus.cmd_dst_ext[JOFF_W-1:0];
    end

    msp_inst_assemble u_assemble (
        .i_cmd        (w_cmd),
        .o_word_c     (w_word),
        .o_need_src_c (w_need_src),
        .o_need_dst_c (w_need_dst),
        .o_illegal_c  (w_illegal)
    );

    // Ready is a pure decode of the state register, gated off during reset
    assign w_cmd_ready = (r_state == ST_IDLE) & ~puc;
    assign w_accept    = bus.cmd_valid & w_cmd_ready;
    assign w_wr_hs     = r_wr_valid & bus.wr_ready;

    // Encoder FSM with registered word-stream outputs
    always_ff @(posedge mclk or posedge puc) begin
        if (puc) begin
            r_state      <= ST_IDLE;
            r_wr_valid   <= 1'b0;
            r_wr_last    <= 1'b0;
            r_wr_data    <= '0;
            r_wr_addr    <= RESET_ADDR;
            r_inst_count <= '0;
            r_cmd_err    <= 1'b0;
            r_need_src   <= 1'b0;
            r_need_dst   <= 1'b0;
            r_src_ext    <= '0;
            r_dst_ext    <= '0;
        end else begin
            r_cmd_err <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (bus.base_load) begin
                    r_wr_addr <= bus.base_addr;
                end
                if (w_accept) begin
                    if (w_illegal) begin
                        r_cmd_err <= 1'b1;
                    end else begin
                        r_state    <= ST_OPW;
                        r_wr_valid <= 1'b1;
                        r_wr_data  <= w_word;
                        r_wr_last  <= ~(w_need_src | w_need_dst);
                        r_need_src <= w_need_src;
                        r_need_dst <= w_need_dst;
                        r_src_ext  <= bus.cmd_src_ext;
                        r_dst_ext  <= bus.cmd_dst_ext;
                    end
                end
            end else if (w_wr_hs) begin
                r_wr_addr <= r_wr_addr + 16'd2;
                if (r_wr_last) begin
                    r_state      <= ST_IDLE;
                    r_wr_valid   <= 1'b0;
                    r_wr_last    <= 1'b0;
                    r_inst_count <= r_inst_count + 32'd1;
                end else if ((r_state == ST_OPW) && r_need_src) begin
                    r_state   <= ST_EXT1;
                    r_wr_data <= r_src_ext;
                    r_wr_last <= ~r_need_dst;
                end else begin
                    r_state   <= ST_EXT2;
                    r_wr_data <= r_dst_ext;
                    r_wr_last <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.wr_valid   = r_wr_valid;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.wr_last    = r_wr_last;
    assign bus.cmd_err    = r_cmd_err;
    assign bus.inst_count = r_inst_count;

endmodule

// File: tb/tb_msp_inst_encoder.sv
// Scoreboard bench for msp_inst_encoder: a word-list reference model fills an
// expectation queue on command acceptance; a monitor pops it on each handshake.
module tb_msp_inst_encoder;

    logic mclk = 1'b0;
    logic puc  = 1'b1;
    always #5 mclk = ~mclk;

    msp_inst_encoder_if bus();

    msp_inst_encoder #(.RESET_ADDR(16'hF000)) dut (
        .mclk (mclk),
        .puc  (puc),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          checks = 0;
    int          passes = 0;
    int          exp_count = 0;
    bit          rdy_rand = 1'b1;
    logic        rdy_val = 1'b0;
    logic [15:0] m_addr = 16'hF000;
    logic        held = 1'b0;
    logic [15:0] h_data, h_addr;
    logic        h_last;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    // Reference: list of words an instruction produces, straight from the encoding rules
    function automatic void model(input logic [1:0] t, input logic [3:0] op, input logic bw,
                                  input logic [3:0] src, input logic [1:0] as_,
                                  input logic [3:0] dst, input logic ad,
                                  input logic [15:0] se, input logic [15:0] de,
                                  output bit ill, output int n, output logic [15:0] ws[3]);
        int  o3 = int'(op) % 8;
        int  v = 0;
        bit  need_s = 1'b0;
        bit  need_d = 1'b0;
        bit  rule = ((as_ == 2'd1) && (src != 4'd3)) || ((as_ == 2'd3) && (src == 4'd0));
        ill = 1'b0;
        ws[0] = '0; ws[1] = '0; ws[2] = '0;
        case (t)
            2'b10: begin
                ill = (int'(op) < 4);
                v = int'(op) * 4096 + int'(src) * 256 + int'(ad) * 128 + int'(bw) * 64
                    + int'(as_) * 16 + int'(dst);
                need_s = rule;
                need_d = ad;
            end
            2'b00: begin
                ill = (o3 == 7);
                if (o3 == 6) v = 'h1300;
                else begin
                    v = 'h1000 + o3 * 128 + int'(bw) * 64 + int'(as_) * 16 + int'(src);
                    need_s = rule;
                end
            end
            2'b01: v = 'h2000 + o3 * 1024 + int'(de) % 1024;
            default: begin
`ifdef MSP_ENC_SWBRK_EN
                v = int'(`DBG_SWBRK_OP);
`else
                ill = 1'b1;
`endif
            end
        endcase
        ws[0] = 16'(v);
        n = 1;
        if (need_s) begin ws[n] = se; n++; end
        if (need_d) begin ws[n] = de; n++; end
    endfunction

    // Ready: random, or a directed level taken from rdy_val
    always @(posedge mclk) begin
        #3;
        bus.wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end

    // Monitor: counter tracking, hold stability, word comparison on handshake
    always @(negedge mclk) begin
        if (puc) begin
            sb.delete();
            exp_count = 0;
            held = 1'b0;
        end else begin
            chk("inst_count", bus.inst_count, 32'(exp_count));
            if (held) begin
                chk("hold_valid", 32'(bus.wr_valid), 32'd1);
                chk("hold_data", 32'(bus.wr_data), 32'(h_data));
                chk("hold_addr", 32'(bus.wr_addr), 32'(h_addr));
                chk("hold_last", 32'(bus.wr_last), 32'(h_last));
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got %h@%h, expected no word", bus.wr_data, bus.wr_addr);
                end else begin
                    m_e = sb.pop_front();
                    chk("word_data", 32'(bus.wr_data), 32'(m_e.data));
                    chk("word_addr", 32'(bus.wr_addr), 32'(m_e.addr));
                    chk("word_last", 32'(bus.wr_last), 32'(m_e.last));
                    if (m_e.last) exp_count++;
                end
            end
            held   = bus.wr_valid && !bus.wr_ready;
            h_data = bus.wr_data;
            h_addr = bus.wr_addr;
            h_last = bus.wr_last;
        end
    end

    task automatic issue(input logic [1:0] t, input logic [3:0] op, input logic bw,
                         input logic [3:0] src, input logic [1:0] as_, input logic [3:0] dst,
                         input logic ad, input logic [15:0] se, input logic [15:0] de,
                         input logic bl, input logic [15:0] ba);
        bit          ill;
        int          n;
        int          k;
        logic [15:0] ws[3];
        exp_t        e;
        model(t, op, bw, src, as_, dst, ad, se, de, ill, n, ws);
        @(posedge mclk); #1;
        bus.cmd_type = t;   bus.cmd_op = op;   bus.cmd_bw = bw;
        bus.cmd_src = src;  bus.cmd_as = as_;  bus.cmd_dst = dst;
        bus.cmd_ad = ad;    bus.cmd_src_ext = se; bus.cmd_dst_ext = de;
        bus.base_load = bl; bus.base_addr = ba; bus.cmd_valid = 1'b1;
        k = 0;
        forever begin
            @(negedge mclk);
            if (bus.cmd_ready || k > 400) break;
            k++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            $display("FAIL accept_timeout: got cmd_ready=0, expected 1 within 400 cycles");
            bus.cmd_valid = 1'b0;
            bus.base_load = 1'b0;
            return;
        end
        if (bl) m_addr = ba;
        if (!ill) begin
            for (int i = 0; i < n; i++) begin
                e.addr = m_addr;
                e.data = ws[i];
                e.last = (i == n - 1);
                sb.push_back(e);
                m_addr = m_addr + 16'd2;
            end
        end
        @(posedge mclk); #1;
        bus.cmd_valid = 1'b0;
        bus.base_load = 1'b0;
        @(negedge mclk);
        if (ill) begin
            chk("err_pulse", 32'(bus.cmd_err), 32'd1);
            chk("err_no_word", 32'(bus.wr_valid), 32'd0);
            @(negedge mclk);
            chk("err_clear", 32'(bus.cmd_err), 32'd0);
        end else begin
            chk("latency_valid", 32'(bus.wr_valid), 32'd1);
            chk("no_err", 32'(bus.cmd_err), 32'd0);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        forever begin
            @(negedge mclk);
            if (bus.cmd_ready || k > 400) break;
            k++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            $display("FAIL idle_timeout: got cmd_ready=0, expected 1 within 400 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge mclk); #1;
        puc = 1'b1;
        @(negedge mclk);
        chk("rst_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_last", 32'(bus.wr_last), 32'd0);
        chk("rst_data", 32'(bus.wr_data), 32'd0);
        chk("rst_addr", 32'(bus.wr_addr), 32'hF000);
        chk("rst_count", bus.inst_count, 32'd0);
        chk("rst_err", 32'(bus.cmd_err), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge mclk); #1;
        puc = 1'b0;
        m_addr = 16'hF000;
        @(negedge mclk);
        chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before 900us");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_type = '0; bus.cmd_op = '0; bus.cmd_bw = 1'b0;
        bus.cmd_src = '0; bus.cmd_as = '0; bus.cmd_dst = '0; bus.cmd_ad = 1'b0;
        bus.cmd_src_ext = '0; bus.cmd_dst_ext = '0; bus.base_load = 1'b0; bus.base_addr = '0;
        repeat (2) @(posedge mclk);
        do_reset();

        // MOV R5,R6: single word at the reset address
        issue(2'b10, 4'd4, 1'b0, 4'd5, 2'd0, 4'd6, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        wait_idle();
        chk("mov_reg_count", bus.inst_count, 32'd1);

        // MOV #0x1234,&0x0200 with a three-cycle stall on the source extension
        do_reset();
        rdy_rand = 1'b0; rdy_val = 1'b0;
        issue(2'b10, 4'd4, 1'b0, 4'd0, 2'd3, 4'd2, 1'b1, 16'h1234, 16'h0200, 1'b0, 16'h0);
        rdy_val = 1'b1;
        @(negedge mclk);
        rdy_val = 1'b0;
        repeat (3) begin
            @(negedge mclk);
            chk("stall_data", 32'(bus.wr_data), 32'h1234);
            chk("stall_addr", 32'(bus.wr_addr), 32'hF002);
            chk("stall_ready", 32'(bus.cmd_ready), 32'd0);
            chk("stall_count", bus.inst_count, 32'd0);
        end
        rdy_rand = 1'b1;
        wait_idle();
        chk("mov_imm_count", bus.inst_count, 32'd1);

        // Reset in the middle of the source extension word
        rdy_rand = 1'b0; rdy_val = 1'b0;
        issue(2'b10, 4'd4, 1'b0, 4'd0, 2'd3, 4'd2, 1'b1, 16'h1234, 16'h0200, 1'b0, 16'h0);
        rdy_val = 1'b1;
        @(negedge mclk);
        rdy_val = 1'b0;
        @(negedge mclk);
        chk("pre_puc_data", 32'(bus.wr_data), 32'h1234);
        #1 puc = 1'b1;
        #1;
        chk("puc_valid", 32'(bus.wr_valid), 32'd0);
        chk("puc_addr", 32'(bus.wr_addr), 32'hF000);
        chk("puc_count", bus.inst_count, 32'd0);
        @(posedge mclk);
        @(negedge mclk);
        @(posedge mclk); #1;
        puc = 1'b0;
        m_addr = 16'hF000;
        rdy_rand = 1'b1;
        @(negedge mclk);
        chk("puc_ready", 32'(bus.cmd_ready), 32'd1);

        // Illegal commands and SBREAK
        issue(2'b10, 4'd2, 1'b0, 4'd1, 2'd0, 4'd4, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        issue(2'b00, 4'd7, 1'b0, 4'd1, 2'd0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        issue(2'b11, 4'd0, 1'b0, 4'd0, 2'd0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // JMP at 0xFFFE via base_load, then RETI wrapping to 0x0000
        issue(2'b01, 4'd7, 1'b0, 4'd0, 2'd0, 4'd0, 1'b0, 16'h0, 16'h03FF, 1'b1, 16'hFFFE);
        issue(2'b00, 4'd6, 1'b0, 4'd0, 2'd0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);

        // Randomized command stream with occasional base reloads
        for (int i = 0; i < 200; i++) begin
            issue(2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 4'($urandom),
                  2'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 7) == 0), 16'($urandom));
        end

        wait_idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge mclk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/msp_inst_encoder.md
MSP_INST_ENCODER -- requirements
Module: msp_inst_encoder

Interface
- REQ-001 SHALL have parameter RESET_ADDR, default 16'hF000: wr_addr value after reset.
- REQ-002 SHALL have clock and reset: one clock; reset is asynchronous and active-high.
  - mclk  in  1  main system clock.
  - puc  in  1  main system reset.
- REQ-003 SHALL have these ports:
  - cmd_valid  in  1  command request.
  - cmd_ready  out  1  command accept.
  - cmd_type  in  2  00 SIG-OP, 01 JUMP, 10 TWO-OP, 11 SBREAK.
  - cmd_op  in  4  TWO-OP opcode[15:12]; SIG-OP/JUMP use cmd_op[2:0].
  - cmd_bw  in  1  byte mode.
  - cmd_src  in  4  source register (SIG-OP operand register).
  - cmd_as  in  2  source addressing mode.
  - cmd_dst  in  4  destination register.
  - cmd_ad  in  1  destination addressing mode.
  - cmd_src_ext  in  16  source extension word.
  - cmd_dst_ext  in  16  destination extension word; [9:0] is the JUMP offset.
  - base_load  in  1  load base_addr into wr_addr.
  - base_addr  in  16  new write address.
  - wr_valid  out  1  word available.
  - wr_ready  in  1  word consumed.
  - wr_addr  out  16  byte address of the word.
  - wr_data  out  16  encoded word.
  - wr_last  out  1  last word of the instruction.
  - cmd_err  out  1  one-cycle illegal-command pulse.
  - inst_count  out  32  instructions fully emitted.

Function
- REQ-004 SHALL be an FSM with states IDLE, OPW, EXT1, EXT2. cmd_ready=1 only in IDLE with puc low. A command is accepted on cmd_valid&cmd_ready.
- REQ-005 SHALL assemble and register the opcode word at acceptance:
  - TWO-OP: {op,src,ad,bw,as,dst}.
  - SIG-OP: {6'b000100,op[2:0],bw,as,src}.
  - RETI (SIG-OP op 6): 16'h1300.
  - JUMP: {3'b001,op[2:0],dst_ext[9:0]}.
- REQ-006 SHALL require a source extension word when (as==01 and src!=3) or (as==11 and src==0). RETI and JUMP never have one.
- REQ-007 SHALL require a destination extension word only for TWO-OP with ad==1. Order on the bus: opcode word, then source extension, then destination extension.
- REQ-008 SHALL give latency 1: a command accepted at edge N gives wr_valid=1 in the cycle after edge N (OPW).
- REQ-009 SHALL hold wr_data/wr_addr/wr_last stable while wr_valid&!wr_ready. State advances only on wr_valid&wr_ready.
- REQ-010 SHALL increment wr_addr by 2 on each word handshake, wrapping 16'hFFFE->16'h0000.
- REQ-011 SHALL assert wr_last on the final word of the instruction, and increment inst_count (wrapping at 2^32) on that word's handshake. Return to IDLE on the same edge.
- REQ-012 SHALL honour base_load only in IDLE. If base_load coincides with command acceptance, the first word uses base_addr. base_load in any other state is ignored.
- REQ-013 SHALL treat as illegal: TWO-OP with op<4, SIG-OP op 7, or SBREAK without REQ-017. An illegal command is consumed, pulses cmd_err the next cycle, produces no word, and leaves inst_count and wr_addr unchanged.
- REQ-014 SHALL let puc mid-instruction abandon remaining words and return to IDLE.

Reset
- REQ-015 SHALL, while puc is high, force state=IDLE, wr_valid=0, wr_last=0, wr_data=0, wr_addr=RESET_ADDR, inst_count=0, cmd_err=0, cmd_ready=0.
- REQ-016 SHALL assert cmd_ready in the first cycle after puc deasserts.

Configuration
- REQ-017 SHALL encode SBREAK when MSP_ENC_SWBRK_EN is defined: cmd_type 11 emits the single word `DBG_SWBRK_OP with wr_last=1. When undefined, cmd_type 11 is illegal per REQ-013.

Structure
- REQ-018 SHALL keep cmd_type codes, FSM state encoding, the RETI constant and the TWO-OP minimum op in shared package msp_enc_pkg.
- REQ-019 SHALL place opcode-word assembly and extension-need flags in combinational sub-module msp_inst_assemble.

Verification
- REQ-020 MOV R5,R6 (type 10, op 4, src 5, as 0, dst 6, ad 0) after reset -> one word 0x4506 at 0xF000, wr_last=1, inst_count=1.
- REQ-021 MOV #0x1234,&0x0200 (src 0, as 11, dst 2, ad 1, src_ext 0x1234, dst_ext 0x0200) -> 0x40B2@F000, 0x1234@F002, 0x0200@F004 (last).
- REQ-022 wr_ready low 3 cycles during EXT1 -> wr_data=0x1234 and wr_addr=0xF002 stable, cmd_ready=0, no inst_count change.
- REQ-023 base_load 0xFFFE then JMP (op 7, offset 0x3FF) followed by RETI -> 0x3FFF@FFFE, then 0x1300@0000.
- REQ-024 TWO-OP op 2 -> cmd_err pulses one cycle, wr_valid stays 0, inst_count unchanged. SBREAK with MSP_ENC_SWBRK_EN defined -> `DBG_SWBRK_OP emitted.
- REQ-025 puc asserted during EXT1 -> wr_valid=0, wr_addr=0xF000, inst_count=0 immediately.
